// File: rtl/full_adder_pkg.sv
// Shared constants and helpers for the registered ripple-carry adder.
// Holds the default width and the signed-overflow helper.
package full_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;

    // Signed overflow: carry into the MSB differs from carry out of it.
    function automatic logic ovf_of(input logic c_msb_in, input logic c_msb_out);
        return c_msb_in ^ c_msb_out;
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational one-bit full-adder cell, chained to form the ripple adder.
// Ports: a, b, c_in -> sum, c_out.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-out and signed overflow.
// Ports: clk, rst, in_valid, a, b, c_in -> sum, c_out, ovf, out_valid.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             out_valid
);

    // carry[i] is the carry into cell i; carry[WIDTH] leaves the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_bit u_bit (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .sum   (sum_comb[i]),
            .c_out (carry[i+1])
        );
    end

    logic [WIDTH-1:0] sum_d,   sum_q;
    logic             c_out_d, c_out_q;
    logic             ovf_d,   ovf_q;
    logic             valid_d, valid_q;

    // Results only load on valid cycles so idle inputs never reach the outputs.
    always_comb begin
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d   = sum_comb;
            c_out_d = carry[WIDTH];
            ovf_d   = ovf_of(carry[WIDTH-1], carry[WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: a 1-bit and an 8-bit instance.
// Checks reset, truth table, wrap, overflow, hold, streaming, mid-stream reset.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst;

    logic       v1, a1, b1, c1;
    logic       s1, co1, ov1, ok1;

    logic       v8, c8;
    logic [7:0] a8, b8;
    logic [7:0] s8;
    logic       co8, ov8, ok8;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .c_in      (c1),
        .sum       (s1),
        .c_out     (co1),
        .ovf       (ov1),
        .out_valid (ok1)
    );

    full_adder #(.WIDTH(8)) u_w8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .c_in      (c8),
        .sum       (s8),
        .c_out     (co8),
        .ovf       (ov8),
        .out_valid (ok8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk8(input string tag, input logic [7:0] es,
                        input logic eco, input logic eov, input logic eok);
        chk({tag, ".sum"},   s8,         es);
        chk({tag, ".c_out"}, {7'd0, co8}, {7'd0, eco});
        chk({tag, ".ovf"},   {7'd0, ov8}, {7'd0, eov});
        chk({tag, ".valid"}, {7'd0, ok8}, {7'd0, eok});
    endtask

    // Truth-table expectations indexed by {a,b,c_in}.
    logic [7:0] tt_sum  = 8'b1001_0110;
    logic [7:0] tt_cout = 8'b1110_1000;
    logic [7:0] tt_ovf  = 8'b0100_0010;

    initial begin
        rst = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        v8 = 1'b1; a8 = 8'hA5; b8 = 8'h3C; c8 = 1'b1;
        tick();
        tick();
        chk("rst_w1.sum",   {7'd0, s1},  8'd0);
        chk("rst_w1.c_out", {7'd0, co1}, 8'd0);
        chk("rst_w1.ovf",   {7'd0, ov1}, 8'd0);
        chk("rst_w1.valid", {7'd0, ok1}, 8'd0);
        chk8("rst_w8", 8'h00, 1'b0, 1'b0, 1'b0);

        rst = 1'b0;
        v8  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = i[2:0];
            v1 = 1'b1;
            tick();
            chk($sformatf("tt%0d.sum", i),   {7'd0, s1},  {7'd0, tt_sum[i]});
            chk($sformatf("tt%0d.c_out", i), {7'd0, co1}, {7'd0, tt_cout[i]});
            chk($sformatf("tt%0d.ovf", i),   {7'd0, ov1}, {7'd0, tt_ovf[i]});
            chk($sformatf("tt%0d.valid", i), {7'd0, ok1}, 8'd1);
        end
        v1 = 1'b0;
        tick();
        chk("w1_idle.valid", {7'd0, ok1}, 8'd0);
        chk("w1_idle.sum",   {7'd0, s1},  8'd1);

        v8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
        tick();
        chk8("wrap", 8'h00, 1'b1, 1'b0, 1'b1);

        a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
        tick();
        chk8("ovf_pos", 8'h80, 1'b0, 1'b1, 1'b1);

        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        tick();
        chk8("ones", 8'hFF, 1'b1, 1'b0, 1'b1);

        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        tick();
        chk8("zeros", 8'h00, 1'b0, 1'b0, 1'b1);

        a8 = 8'h10; b8 = 8'h02; c8 = 1'b0;
        tick();
        chk8("load12", 8'h12, 1'b0, 1'b0, 1'b1);

        v8 = 1'b0; a8 = 8'hAB; b8 = 8'hCD; c8 = 1'b1;
        tick();
        chk8("hold1", 8'h12, 1'b0, 1'b0, 1'b0);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'bx;
        tick();
        chk8("hold2", 8'h12, 1'b0, 1'b0, 1'b0);

        v8 = 1'b1; c8 = 1'b0;
        a8 = 8'd3;   b8 = 8'd4;
        tick();
        chk8("bb0", 8'd7, 1'b0, 1'b0, 1'b1);
        a8 = 8'd10;  b8 = 8'd20;
        tick();
        chk8("bb1", 8'd30, 1'b0, 1'b0, 1'b1);
        a8 = 8'd255; b8 = 8'd1;
        tick();
        chk8("bb2", 8'd0, 1'b1, 1'b0, 1'b1);
        a8 = 8'd128; b8 = 8'd128;
        tick();
        chk8("bb3", 8'd0, 1'b1, 1'b1, 1'b1);

        a8 = 8'd5; b8 = 8'd6; rst = 1'b1;
        tick();
        chk8("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        a8 = 8'd1; b8 = 8'd2; c8 = 1'b1;
        tick();
        chk8("after_rst", 8'd4, 1'b0, 1'b0, 1'b1);
        v8 = 1'b0;
        tick();
        chk8("after_idle", 8'd4, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
